fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the 5-stage pipeline, generalising EX-stage operand forwarding and decode-stage internal bypass to NUM_SRC source operands. It adds load-use stall generation, a scoreboard for one outstanding multi-cycle (MUL/DIV) operation with self-timed completion, and a saturating stall-cycle counter. It sits beside the ID/EX pipeline registers and drives the operand muxes in ID and EX plus the IF/ID and PC hold controls.

---
 rtl/fwd_hazard_unit.sv | 150 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding / hazard unit: per-source EX forwarding and ID bypass selection,
// load-use and multi-cycle hazard stalls, MD scoreboard and stall-cycle counter.

module fwd_hazard_src #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic              i_id_used,
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_md_rd,
  input  logic              i_md_fire,
  output logic [1:0]        o_fwd_sel,
  output logic [1:0]        o_id_bypass,
  output logic              o_hit_ex,
  output logic              o_hit_md
);
  // x0 is hardwired zero, so it never produces a dependency
  function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    o_fwd_sel = 2'b00;
    if (i_mem_we && match(i_ex_rs, i_mem_rd))       o_fwd_sel = 2'b10;
    else if (i_md_fire && match(i_ex_rs, i_md_rd))  o_fwd_sel = 2'b11;
    else if (i_wb_we && match(i_ex_rs, i_wb_rd))    o_fwd_sel = 2'b01;

    o_id_bypass = 2'b00;
    if (i_id_used) begin
      if (i_md_fire && match(i_id_rs, i_md_rd))     o_id_bypass = 2'b10;
      else if (i_wb_we && match(i_id_rs, i_wb_rd))  o_id_bypass = 2'b01;
    end

    o_hit_ex = i_id_used && match(i_id_rs, i_ex_rd);
    o_hit_md = i_id_used && match(i_id_rs, i_md_rd);
  end
endmodule

module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_num,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      id_md_start,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_num,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      ex_reg_write,
  input  logic                      mem_reg_write,
  input  logic                      wb_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_md_start,
  input  logic                      flush,
  input  logic                      stall_cnt_clr,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_SRC*2-1:0]      id_bypass,
  output logic                      stall,
  output logic                      md_busy,
  output logic [REG_AW-1:0]         md_rd,
  output logic                      md_wb_fire,
  output logic [CNT_W-1:0]          stall_cnt
);
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} md_state_e;

  md_state_e          r_state;
  logic [3:0]         r_cnt;
  logic [REG_AW-1:0]  r_md_rd;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [NUM_SRC-1:0] w_hit_ex;
  logic [NUM_SRC-1:0] w_hit_md;
  logic               w_md_fire;
  logic               w_md_pending;
  logic               w_stall;

  assign w_md_fire    = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_md_pending = (r_state == S_BUSY) && !w_md_fire;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_hazard_src #(.REG_AW(REG_AW)) u_src (
        .i_id_rs     (id_rs_num[g*REG_AW +: REG_AW]),
        .i_id_used   (id_rs_used[g]),
        .i_ex_rs     (ex_rs_num[g*REG_AW +: REG_AW]),
        .i_ex_rd     (ex_rd),
        .i_mem_rd    (mem_rd),
        .i_mem_we    (mem_reg_write),
        .i_wb_rd     (wb_rd),
        .i_wb_we     (wb_reg_write),
        .i_md_rd     (r_md_rd),
        .i_md_fire   (w_md_fire),
        .o_fwd_sel   (fwd_sel[g*2 +: 2]),
        .o_id_bypass (id_bypass[g*2 +: 2]),
        .o_hit_ex    (w_hit_ex[g]),
        .o_hit_md    (w_hit_md[g])
      );
    end
  endgenerate

  // A dependent instruction may proceed in the completion cycle via the MD bypass
  assign w_stall = !flush && (
      (ex_mem_read && ex_reg_write && |w_hit_ex) ||
      (w_md_pending && |w_hit_md) ||
      (ex_md_start && |w_hit_ex) ||
      (id_md_start && (ex_md_start || w_md_pending)));

  // Flush does not cancel an outstanding op: it is older than anything flushed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_md_rd <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (ex_md_start && !flush) begin
          r_state <= S_BUSY;
          r_md_rd <= ex_rd;
          r_cnt   <= 4'(MD_LATENCY - 1);
        end
        S_BUSY: if (r_cnt == 4'd0) r_state <= S_IDLE;
                else               r_cnt   <= r_cnt - 4'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   r_stall_cnt <= '0;
    else if (stall_cnt_clr)         r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall      = w_stall;
  assign md_busy    = (r_state == S_BUSY);
  assign md_rd      = r_md_rd;
  assign md_wb_fire = w_md_fire;
  assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Random + directed bench for fwd_hazard_unit against a cycle-count based model.
module tb_fwd_hazard_unit;
  localparam int REG_AW = 5, NUM_SRC = 2, L = 4, CNT_W = 6;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 0, reset_n = 0;
  logic [NUM_SRC*REG_AW-1:0] id_rs_num, ex_rs_num;
  logic [NUM_SRC-1:0] id_rs_used;
  logic id_md_start, ex_reg_write, mem_reg_write, wb_reg_write;
  logic ex_mem_read, ex_md_start, flush, stall_cnt_clr;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [NUM_SRC*2-1:0] fwd_sel, id_bypass;
  logic stall, md_busy, md_wb_fire;
  logic [REG_AW-1:0] md_rd;
  logic [CNT_W-1:0] stall_cnt;

  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MD_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs_num(id_rs_num), .id_rs_used(id_rs_used),
    .id_md_start(id_md_start), .ex_rs_num(ex_rs_num), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .wb_rd(wb_rd), .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start),
    .flush(flush), .stall_cnt_clr(stall_cnt_clr), .fwd_sel(fwd_sel), .id_bypass(id_bypass),
    .stall(stall), .md_busy(md_busy), .md_rd(md_rd), .md_wb_fire(md_wb_fire),
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  // model: MD op launched in cycle m_launch, result written L cycles later
  int cyc = 0, m_launch = -1, m_scnt = 0;
  logic [REG_AW-1:0] m_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return m_launch >= 0 && cyc > m_launch && cyc <= m_launch + L;
  endfunction
  function automatic bit m_fire();
    return m_launch >= 0 && cyc == m_launch + L;
  endfunction
  function automatic bit dep(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return a != 0 && a == b;
  endfunction

  task automatic quiet();
    id_rs_num = '0; ex_rs_num = '0; id_rs_used = '0; id_md_start = 0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0; ex_reg_write = 0; mem_reg_write = 0;
    wb_reg_write = 0; ex_mem_read = 0; ex_md_start = 0; flush = 0; stall_cnt_clr = 0;
  endtask

  // Check every output against the model for the current inputs, then advance one clock
  task automatic step();
    logic [1:0] ef, eb;
    logic [REG_AW-1:0] s;
    bit hit_ex, hit_md, est;
    #1;
    hit_ex = 0; hit_md = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = ex_rs_num[i*REG_AW +: REG_AW];
      if (mem_reg_write && dep(s, mem_rd))   ef = 2'b10;
      else if (m_fire() && dep(s, m_rd))     ef = 2'b11;
      else if (wb_reg_write && dep(s, wb_rd)) ef = 2'b01;
      else                                   ef = 2'b00;
      chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i*2 +: 2]), 32'(ef));
      s = id_rs_num[i*REG_AW +: REG_AW];
      eb = 2'b00;
      if (id_rs_used[i]) begin
        if (m_fire() && dep(s, m_rd))           eb = 2'b10;
        else if (wb_reg_write && dep(s, wb_rd)) eb = 2'b01;
        if (dep(s, ex_rd)) hit_ex = 1;
        if (dep(s, m_rd))  hit_md = 1;
      end
      chk($sformatf("id_bypass[%0d]", i), 32'(id_bypass[i*2 +: 2]), 32'(eb));
    end
    est = !flush && ((ex_mem_read && ex_reg_write && hit_ex) ||
                     (m_busy() && !m_fire() && hit_md) ||
                     (ex_md_start && hit_ex) ||
                     (id_md_start && (ex_md_start || (m_busy() && !m_fire()))));
    chk("stall", 32'(stall), 32'(est));
    chk("md_busy", 32'(md_busy), 32'(m_busy()));
    chk("md_wb_fire", 32'(md_wb_fire), 32'(m_fire()));
    if (m_busy()) chk("md_rd", 32'(md_rd), 32'(m_rd));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    if (ex_md_start && !flush && !m_busy()) begin m_launch = cyc; m_rd = ex_rd; end
    if (stall_cnt_clr) m_scnt = 0;
    else if (est && m_scnt < CMAX) m_scnt++;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    quiet();
    repeat (3) @(negedge clk);
    #1;
    chk("rst md_busy", 32'(md_busy), 0);
    chk("rst md_rd", 32'(md_rd), 0);
    chk("rst md_wb_fire", 32'(md_wb_fire), 0);
    chk("rst stall_cnt", 32'(stall_cnt), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst fwd_sel", 32'(fwd_sel), 0);
    reset_n = 1;
    @(negedge clk);

    // forwarding priority and x0
    quiet(); mem_reg_write = 1; wb_reg_write = 1; mem_rd = 5; wb_rd = 5;
    ex_rs_num[REG_AW-1:0] = 5; #1; chk("dir fwd memwb", 32'(fwd_sel[1:0]), 2); step();
    mem_reg_write = 0; #1; chk("dir fwd wb", 32'(fwd_sel[1:0]), 1); step();
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs_num = '0; #1;
    chk("dir fwd x0", 32'(fwd_sel[1:0]), 0); step();

    // load-use on operand 1, then same with flush
    quiet(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7;
    id_rs_num[REG_AW +: REG_AW] = 7; id_rs_used = 2'b10; #1;
    chk("dir loaduse", 32'(stall), 1); step();
    flush = 1; #1; chk("dir loaduse flush", 32'(stall), 0); step();

    // MD dependent: stall 3 cycles, proceed with bypass on completion
    quiet(); ex_md_start = 1; ex_rd = 9; ex_reg_write = 1; step();
    for (int k = 1; k <= L; k++) begin
      quiet(); id_rs_num[REG_AW-1:0] = 9; id_rs_used = 2'b01; #1;
      chk("dir md stall", 32'(stall), 32'(k < L));
      if (k == L) begin
        chk("dir md fire", 32'(md_wb_fire), 1);
        chk("dir md bypass", 32'(id_bypass[1:0]), 2);
      end
      step();
    end
    quiet(); #1; chk("dir md done", 32'(md_busy), 0); step();

    // structural: second MD op waits until the completion cycle, then launches
    quiet(); ex_md_start = 1; ex_rd = 3; step();
    for (int k = 1; k <= L; k++) begin
      quiet(); id_md_start = 1; #1;
      chk("dir struct stall", 32'(stall), 32'(k < L)); step();
    end
    quiet(); ex_md_start = 1; ex_rd = 4; step();
    quiet(); #1; chk("dir relaunch busy", 32'(md_busy), 1); step();
    step();

    // async reset mid-op
    @(negedge clk); #1 reset_n = 0; #1;
    chk("rst mid busy", 32'(md_busy), 0);
    chk("rst mid md_rd", 32'(md_rd), 0);
    chk("rst mid stall_cnt", 32'(stall_cnt), 0);
    m_launch = -1; m_rd = '0; m_scnt = 0;
    @(negedge clk); reset_n = 1;
    for (int k = 0; k < L + 2; k++) step();

    // saturation and clear-over-increment
    quiet(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7;
    id_rs_num[REG_AW-1:0] = 7; id_rs_used = 2'b01;
    repeat ((1 << CNT_W) + 3) step();
    chk("dir sat", 32'(stall_cnt), CMAX);
    stall_cnt_clr = 1; step();
    stall_cnt_clr = 0; #1; chk("dir clr", 32'(stall_cnt), 0); step();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        id_rs_num[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        ex_rs_num[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      end
      id_rs_used = NUM_SRC'($urandom);
      ex_rd = REG_AW'($urandom_range(0, 7));
      mem_rd = REG_AW'($urandom_range(0, 7));
      wb_rd = REG_AW'($urandom_range(0, 7));
      ex_reg_write = 1'($urandom); mem_reg_write = 1'($urandom);
      wb_reg_write = 1'($urandom); ex_mem_read = ($urandom_range(0, 3) == 0);
      id_md_start = ($urandom_range(0, 4) == 0);
      ex_md_start = !m_busy() && ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall_cnt_clr = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
